// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, command bytes, frame geometry.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6,
    S_ERR       = 3'd7
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned DATA_BITS = 8;

  // Odd parity bit for a data byte
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pad conditioning: 2-FF synchronisers on clock and data, glitch filter
// on the clock level, and a one-cycle pulse on each filtered falling edge.
module ps2_line_sync #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c_raw,
  input  logic ps2d_raw,
  output logic ps2c_level,
  output logic ps2d_sync,
  output logic ps2c_fall
);

  localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       c_sr;
  logic [1:0]       d_sr;
  logic [FLT_W-1:0] flt_cnt;

  // Synchronise both pads; accept a new clock level after FILTER_LEN equal samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_sr       <= 2'b11;
      d_sr       <= 2'b11;
      flt_cnt    <= '0;
      ps2c_level <= 1'b1;
      ps2c_fall  <= 1'b0;
    end else begin
      c_sr      <= {c_sr[0], ps2c_raw};
      d_sr      <= {d_sr[0], ps2d_raw};
      ps2c_fall <= 1'b0;
      if (c_sr[1] != ps2c_level) begin
        if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
          ps2c_level <= c_sr[1];
          ps2c_fall  <= ~c_sr[1];
          flt_cnt    <= '0;
        end else begin
          flt_cnt <= flt_cnt + FLT_W'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign ps2d_sync = d_sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift the frame
// out on device clock falls, check the device ACK, report done or error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = 12_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // INHIBIT_CYCLES = 0 selects 100 us derived from the clock frequency
  localparam int unsigned INHIBIT_MIN = CLK_FREQ_HZ / 10_000;
  localparam int unsigned INHIBIT_LEN = (INHIBIT_CYCLES != 0) ? INHIBIT_CYCLES : INHIBIT_MIN;
  localparam int unsigned CNT_MAX     = (INHIBIT_LEN > TIMEOUT_CYCLES) ? INHIBIT_LEN : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W       = 4;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 2);

  ps2_tx_state_t    state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
  logic [8:0]       frame, frame_d;
  logic             dlow_d;
  logic             c_level, d_sync, c_fall;
  logic             timeout_c;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2c_raw   (ps2c_in),
    .ps2d_raw   (ps2d_in),
    .ps2c_level (c_level),
    .ps2d_sync  (d_sync),
    .ps2c_fall  (c_fall)
  );

  assign timeout_c = (cnt >= CNT_W'(TIMEOUT_CYCLES - 1));

  // Next state, counters, shift register and data-line drive
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CNT_W'(1);
    bit_cnt_d = bit_cnt;
    frame_d   = frame;
    dlow_d    = ps2d_oe;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          frame_d = {odd_parity(tx_data), tx_data};
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == CNT_W'(INHIBIT_LEN - 1)) begin
          cnt_d   = '0;
          dlow_d  = 1'b1;
          state_d = S_RTS;
        end
      end
      S_RTS: begin
        if (c_fall) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = S_SHIFT;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_SHIFT: begin
        if (c_fall) begin
          cnt_d     = '0;
          dlow_d    = ~frame[0];
          frame_d   = {1'b1, frame[8:1]};
          bit_cnt_d = bit_cnt + BIT_W'(1);
          if (bit_cnt == LAST_BIT) state_d = S_ACK;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_ACK: begin
        if (c_fall) begin
          cnt_d   = '0;
          state_d = d_sync ? S_ERR : S_WAIT_IDLE;
        end else if (timeout_c) begin
          state_d = S_ERR;
        end
      end
      S_WAIT_IDLE: begin
        if (c_fall) cnt_d = '0;
        if (c_level && d_sync) state_d = S_DONE;
        else if (timeout_c)    state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d inside {S_IDLE, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR}) dlow_d = 1'b0;
  end

  // State register and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      frame    <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      ps2c_oe  <= 1'b0;
      ps2d_oe  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_cnt  <= bit_cnt_d;
      frame    <= frame_d;
      tx_ready <= (state_d == S_IDLE);
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_DONE);
      error    <= (state_d == S_ERR);
      ps2c_oe  <= (state_d == S_INHIBIT);
      ps2d_oe  <= dlow_d;
    end
  end

endmodule
